mm_line_responder: RTL and testbench
====================================

// Module: mm_line_responder
// PURPOSE
//  Main-memory responder for the L1 cache controller: the far end of its FILL/RD_ALLOC line reads and WR_EVICT/RD_EVICT line writebacks.
//  Accepts one line-wide request at a time, applies a fixed per-type latency, then returns read data or a write acknowledge.
//  Backing store is a line-organised RAM sub-module, preloadable by the bench through hierarchical access.
// PARAMETERS
//  ADDR_W   26   line-address width on the request port
//  MEM_AW   16   implemented RAM depth = 2**MEM_AW lines; req_addr[ADDR_W-1:MEM_AW] ignored (aliases)
//  LINE_W   256  line width in bits (8 x 32-bit words)
//  RD_LAT   4    accept edge to rsp_valid, in cycles; legal range 2..15
//  WR_LAT   2    accept edge to RAM write / wr_done, in cycles; legal range 1..15
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  reset      in   1        asynchronous, active-high reset
//  req_valid  in   1        request present
//  req_ready  out  1        responder idle, can accept
//  req_write  in   1        1 = line write (evict), 0 = line read (fill)
//  req_addr   in   ADDR_W   line address
//  req_wdata  in   LINE_W   write line data
//  rsp_valid  out  1        read data valid; held until rsp_ready
//  rsp_ready  in   1        cache accepts read data
//  rsp_rdata  out  LINE_W   read line data; stable while rsp_valid
//  wr_done    out  1        one-cycle pulse: write committed to RAM
//  cap_count  out  5        writes captured, saturates at 16 (MM_CAPTURE_EN)
//  cap_idx    in   4        capture entry select (MM_CAPTURE_EN)
//  cap_addr   out  32       captured address, zero-extended (MM_CAPTURE_EN)
//  cap_data   out  32       captured word 0 of the line (MM_CAPTURE_EN)
// BEHAVIOUR
//  Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, wr_done=0, cap_count=0; FSM=IDLE; latency counter=0. RAM contents are not reset.
//  Accept occurs on the edge where req_valid & req_ready are both high. req_ready=1 only in IDLE, so there is a single outstanding request.
//  Address, write flag and data are registered at accept; request inputs are don't-care afterwards.
//  FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT.
//  IDLE -> RD_WAIT on read accept; latency counter loads RD_LAT-1.
//  IDLE -> WR_WAIT on write accept; latency counter loads WR_LAT-1.
//  RD_WAIT: counter decrements each cycle. At count==1 the RAM read is issued. rsp_valid and rsp_rdata are registered so rsp_valid rises exactly RD_LAT cycles after the accept edge. Then -> RD_RESP.
//  RD_RESP: hold rsp_valid and rsp_rdata until rsp_ready is high at an edge; then rsp_valid=0 and state -> IDLE. req_ready rises at that same edge.
//  WR_WAIT: at count==0 the RAM write occurs on that edge; wr_done=1 for the following cycle only; -> IDLE.
//  Back-to-back: a new accept is possible in the cycle after return to IDLE. There is no bypass or forwarding.
//  Read-after-write to the same address returns the new data, because the write commits before IDLE.
//  Address wrap: the RAM index is req_addr[MEM_AW-1:0]. Addresses 0x0_0000 and 0x1_0000 hit the same line.
//  rsp_ready high outside RD_RESP is ignored.
//  Reset mid-operation: FSM returns to IDLE and any pending read or write is dropped. No RAM write occurs for a dropped write.
// CONFIGURATION
//  `MM_CAPTURE_EN defined: 16-entry circular log of committed writes.
//    Each entry stores {addr zero-extended to 32 bits, line[31:0]} and is written on the wr_done edge.
//    The write pointer wraps from 15 to 0. cap_count saturates at 16.
//    cap_addr and cap_data are combinational reads of entry cap_idx. Reset clears the pointer and cap_count only.
//  `MM_CAPTURE_EN undefined: no capture storage is built. cap_count, cap_addr and cap_data are tied to 0 and cap_idx is unused.
// STRUCTURE
//  Shared package mm_resp_pkg holds the FSM state encoding (2-bit localparams IDLE/RD_WAIT/RD_RESP/WR_WAIT) and the CAP_DEPTH=16 constant.
//  Sub-module mm_line_ram (MEM_AW, LINE_W): single-port synchronous RAM with 1-cycle read. Its storage array is named ram for bench preload.
//  The FSM, latency counter and capture log live in mm_line_responder.
// TESTING
//  1. Preload ram[0x0010] with 0xA5..A5. Read 0x0010 with rsp_ready=1 -> rsp_valid at accept+4 with data 0xA5..A5, high for 1 cycle; req_ready=1 the next cycle.
//  2. Write 0x0003 with data word0=0xDEADBEEF, then read 0x0003 -> wr_done at accept+2; read returns word0 0xDEADBEEF.
//  3. Read with rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable throughout; req_ready=0 until the rsp_ready edge.
//  4. Write 0x1_0005, then read 0x0_0005 -> same data returned (alias). Assert reset at accept+1 of a write -> RAM unchanged, no wr_done, req_ready=1.
//  5. With MM_CAPTURE_EN, 18 writes to 0..17 -> cap_count=16; cap_idx 0 shows addr 16, cap_idx 1 shows addr 17. Without it -> all cap outputs 0.

Source files
------------

// File: rtl/mm_resp_pkg.sv
// Shared definitions for the main-memory line responder: FSM state encoding
// and capture-log depth.
package mm_resp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t RD_WAIT = 2'd1;
    localparam state_t RD_RESP = 2'd2;
    localparam state_t WR_WAIT = 2'd3;

    localparam int CAP_DEPTH = 16;

endpackage

// File: rtl/mm_line_ram.sv
// Line-organised single-port RAM with a one-cycle registered read.
// Storage array is named ram so a bench can reach it hierarchically.
module mm_line_ram #(
    parameter int MEM_AW = 16,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] ram [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                ram[addr] <= wdata;
            else
                rdata <= ram[addr];
        end
    end

endmodule

// File: rtl/mm_line_responder.sv
// Main-memory responder: one outstanding line read or write, fixed per-type latency.
// Optional write capture log enabled by defining MM_CAPTURE_EN.
//
// state   | meaning
// IDLE    | ready for a new request
// RD_WAIT | counting read latency, RAM read issued at count 1
// RD_RESP | holding read data until rsp_ready
// WR_WAIT | counting write latency, RAM write at count 0
module mm_line_responder
    import mm_resp_pkg::*;
#(
    parameter int ADDR_W = 26,
    parameter int MEM_AW = 16,
    parameter int LINE_W = 256,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              wr_done,
    output logic [4:0]        cap_count,
    input  logic [3:0]        cap_idx,
    output logic [31:0]       cap_addr,
    output logic [31:0]       cap_data
);

    localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

    state_t            state, state_nxt;
    logic [3:0]        lat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] ram_rdata;
    logic              accept;
    logic              ram_en;
    logic              ram_we;
    logic              rd_load;
    logic              rsp_take;
    logic              wr_commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_write ? WR_WAIT : RD_WAIT;
            RD_WAIT: if (lat_cnt == 4'd0) state_nxt = RD_RESP;
            RD_RESP: if (rsp_ready) state_nxt = IDLE;
            WR_WAIT: if (lat_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        accept    = req_ready && req_valid;
        rd_load   = (state == RD_WAIT) && (lat_cnt == 4'd0);
        rsp_take  = (state == RD_RESP) && rsp_ready;
        wr_commit = (state == WR_WAIT) && (lat_cnt == 4'd0);
        ram_we    = wr_commit;
        ram_en    = wr_commit || ((state == RD_WAIT) && (lat_cnt == 4'd1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_done   <= 1'b0;
        end else begin
            wr_done <= wr_commit;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                lat_cnt <= req_write ? WR_LOAD : RD_LOAD;
            end else if (((state == RD_WAIT) || (state == WR_WAIT)) && (lat_cnt != 4'd0)) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (rd_load) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= ram_rdata;
            end else if (rsp_take) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Upper address bits alias onto the implemented depth.
    mm_line_ram #(
        .MEM_AW (MEM_AW),
        .LINE_W (LINE_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[MEM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

`ifdef MM_CAPTURE_EN
    logic [31:0] cap_addr_mem [CAP_DEPTH];
    logic [31:0] cap_data_mem [CAP_DEPTH];
    logic [3:0]  cap_ptr;

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            cap_addr_mem[cap_ptr] <= 32'(addr_q);
            cap_data_mem[cap_ptr] <= wdata_q[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_ptr   <= '0;
            cap_count <= '0;
        end else if (wr_commit) begin
            cap_ptr <= cap_ptr + 4'd1;
            if (cap_count != 5'(CAP_DEPTH))
                cap_count <= cap_count + 5'd1;
        end
    end

    assign cap_addr = cap_addr_mem[cap_idx];
    assign cap_data = cap_data_mem[cap_idx];
`else
    logic unused_bits;

    assign unused_bits = ^{cap_idx, addr_q[ADDR_W-1:MEM_AW]};
    assign cap_count   = '0;
    assign cap_addr    = '0;
    assign cap_data    = '0;
`endif

endmodule

// File: tb/tb_mm_line_responder.sv
// Directed bench for mm_line_responder: latency, hold, alias, reset drop and
// the optional write capture log.
module tb_mm_line_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [25:0]  req_addr;
    logic [255:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [255:0] rsp_rdata;
    logic         wr_done;
    logic [4:0]   cap_count;
    logic [3:0]   cap_idx;
    logic [31:0]  cap_addr;
    logic [31:0]  cap_data;

    int n_checks = 0;
    int n_errors = 0;

    mm_line_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .wr_done   (wr_done),
        .cap_count (cap_count),
        .cap_idx   (cap_idx),
        .cap_addr  (cap_addr),
        .cap_data  (cap_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request for one edge, then scramble the request inputs.
    task automatic issue(input logic wr, input logic [25:0] a, input logic [255:0] d);
        @(negedge clk);
        check("accept_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 26'($urandom);
        req_wdata = {8{$urandom}};
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 30);
        if (!rsp_valid) lat = -1;
    endtask

    task automatic wait_wr(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!wr_done && lat < 30);
        if (!wr_done) lat = -1;
    endtask

    task automatic do_write(input logic [25:0] a, input logic [255:0] d);
        int lat;
        issue(1'b1, a, d);
        wait_wr(lat);
        check("wr_latency", 32'(lat), 32'd2);
        @(negedge clk);
        check("wr_done_pulse", wr_done, 1'b0);
        check("wr_ready_back", req_ready, 1'b1);
    endtask

    task automatic do_read(input logic [25:0] a, input logic [255:0] exp);
        int lat;
        rsp_ready = 1'b1;
        issue(1'b0, a, '0);
        wait_rsp(lat);
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_data", rsp_rdata, exp);
        @(negedge clk);
        check("rd_valid_drop", rsp_valid, 1'b0);
        check("rd_ready_back", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] line_a5, line_t2, line_t3, line_t4, line_p, line_q, held;
        int           lat;
        logic         seen_done;

        line_a5 = {8{32'hA5A5_A5A5}};
        line_t2 = {224'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE, 32'hDEAD_BEEF};
        line_t3 = {8{32'h0BAD_F00D}} ^ {32'h1, 192'h0, 32'h2};
        line_t4 = {8{32'h5A5A_0F0F}} + 256'h1234;
        line_p  = {8{32'hCAFE_0007}};
        line_q  = {8{32'h0000_0BAD}};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        cap_idx   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_wr_done", wr_done, 1'b0);
        check("rst_cap_count", cap_count, 5'd0);
        reset = 1'b0;

        // Read of a written line with rsp_ready held high.
        do_write(26'h0010, line_a5);
        do_read(26'h0010, line_a5);

        // Read-after-write at another address.
        do_write(26'h0003, line_t2);
        do_read(26'h0003, line_t2);

        // Response held while rsp_ready stays low.
        do_write(26'h0020, line_t3);
        rsp_ready = 1'b0;
        issue(1'b0, 26'h0020, '0);
        wait_rsp(lat);
        check("hold_latency", 32'(lat), 32'd4);
        held = rsp_rdata;
        check("hold_data", held, line_t3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_stable", rsp_rdata, line_t3);
            check("hold_not_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_release_valid", rsp_valid, 1'b0);
        check("hold_release_ready", req_ready, 1'b1);

        // Upper address bits alias onto the same line.
        do_write(26'h1_0005, line_t4);
        do_read(26'h0_0005, line_t4);

        // Reset one cycle into a write drops it.
        do_write(26'h0007, line_p);
        issue(1'b1, 26'h0007, line_q);
        reset     = 1'b1;
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wr_done) seen_done = 1'b1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wr_done) seen_done = 1'b1;
        end
        check("rst_drop_no_done", seen_done, 1'b0);
        check("rst_drop_ready", req_ready, 1'b1);
        check("rst_drop_ram", dut.u_ram.ram[7], line_p);
        check("rst_drop_cap", cap_count, 5'd0);
        do_read(26'h0007, line_p);

        // Capture log: fresh reset, then 18 writes to addresses 0..17.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            do_write(26'(i), {224'h0, 32'h1000 + 32'(i)});
`ifdef MM_CAPTURE_EN
            if (i == 2) check("cap_count_3", cap_count, 5'd3);
`endif
        end
        @(negedge clk);
`ifdef MM_CAPTURE_EN
        check("cap_count_sat", cap_count, 5'd16);
        cap_idx = 4'd0;
        #1;
        check("cap0_addr", cap_addr, 32'd16);
        check("cap0_data", cap_data, 32'h1010);
        cap_idx = 4'd1;
        #1;
        check("cap1_addr", cap_addr, 32'd17);
        check("cap1_data", cap_data, 32'h1011);
        cap_idx = 4'd2;
        #1;
        check("cap2_addr", cap_addr, 32'd2);
        cap_idx = 4'd15;
        #1;
        check("cap15_addr", cap_addr, 32'd15);
        check("cap15_data", cap_data, 32'h100F);
`else
        check("nocap_count", cap_count, 5'd0);
        cap_idx = 4'd1;
        #1;
        check("nocap_addr", cap_addr, 32'd0);
        check("nocap_data", cap_data, 32'd0);
`endif
        do_read(26'h0011, {224'h0, 32'h1011});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
